dm_arbiter: RTL

DM_ARBITER -- requirements
Module: dm_arbiter

---
 rtl/dm_arbiter.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/dm_arbiter.sv
// Two-master arbiter for a single-ported data memory: the CPU M-stage and a
// secondary loader/debug master share the port with round-robin tie-breaking.
module dm_arbiter #(
    parameter int WAIT_CYCLES = 1
) (
    input  logic        clk,
    input  logic        reset,

    input  logic        cpu_req,
    input  logic [31:0] cpu_addr,
    input  logic [31:0] cpu_wdata,
    input  logic [3:0]  cpu_byteen,
    output logic [31:0] cpu_rdata,
    output logic        cpu_stall,

    input  logic        ext_req,
    input  logic [31:0] ext_addr,
    input  logic [31:0] ext_wdata,
    input  logic [3:0]  ext_byteen,
    output logic [31:0] ext_rdata,
    output logic        ext_done,

    output logic        mem_en,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_byteen,
    input  logic [31:0] mem_rdata
);

    // A zero wait count still needs one access cycle; the counter is 4 bits wide.
    localparam int WAIT_EFF = (WAIT_CYCLES < 1)  ? 1  :
                              (WAIT_CYCLES > 15) ? 15 : WAIT_CYCLES;
    localparam logic [3:0] CNT_LOAD = 4'(WAIT_EFF - 1);

    typedef enum logic [2:0] {
        IDLE,
        ACC_CPU,
        ACC_EXT,
        DONE_CPU,
        DONE_EXT
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic        last_ext;
    logic        last_ext_nxt;
    logic        grant_cpu;
    logic        grant_ext;
    logic        in_acc;
    logic        final_acc;

    logic [3:0]  cnt_p1;
    logic [31:0] addr_p1;
    logic [31:0] wdata_p1;
    logic [3:0]  byteen_p1;

    always_comb begin
        in_acc    = (state == ACC_CPU) || (state == ACC_EXT);
        final_acc = in_acc && (cnt_p1 == 4'd0);
    end

    // Next-state and grant decision; a DONE state never re-serves its own master.
    always_comb begin
        state_nxt    = state;
        last_ext_nxt = last_ext;
        grant_cpu    = 1'b0;
        grant_ext    = 1'b0;
        case (state)
            IDLE: begin
                if (cpu_req && ext_req) begin
                    grant_cpu = last_ext;
                    grant_ext = !last_ext;
                end else if (cpu_req) begin
                    grant_cpu = 1'b1;
                end else if (ext_req) begin
                    grant_ext = 1'b1;
                end
            end
            ACC_CPU: begin
                if (final_acc) state_nxt = DONE_CPU;
            end
            ACC_EXT: begin
                if (final_acc) state_nxt = DONE_EXT;
            end
            DONE_CPU: begin
                last_ext_nxt = 1'b0;
                if (ext_req) grant_ext = 1'b1;
                else         state_nxt = IDLE;
            end
            DONE_EXT: begin
                last_ext_nxt = 1'b1;
                if (cpu_req) grant_cpu = 1'b1;
                else         state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
        if (grant_cpu)      state_nxt = ACC_CPU;
        else if (grant_ext) state_nxt = ACC_EXT;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            last_ext <= 1'b1;
            cnt_p1   <= 4'd0;
        end else begin
            state    <= state_nxt;
            last_ext <= last_ext_nxt;
            if (grant_cpu || grant_ext) begin
                cnt_p1 <= CNT_LOAD;
            end else if (in_acc && (cnt_p1 != 4'd0)) begin
                cnt_p1 <= cnt_p1 - 4'd1;
            end
        end
    end

    // Access stage: winner's request captured on the grant edge.
    always_ff @(posedge clk) begin
        if (grant_cpu) begin
            addr_p1   <= cpu_addr;
            wdata_p1  <= cpu_wdata;
            byteen_p1 <= cpu_byteen;
        end else if (grant_ext) begin
            addr_p1   <= ext_addr;
            wdata_p1  <= ext_wdata;
            byteen_p1 <= ext_byteen;
        end
    end

    // Completion stage: read data lands in the served master's register.
    always_ff @(posedge clk) begin
        if (reset) begin
            cpu_rdata <= 32'd0;
            ext_rdata <= 32'd0;
        end else if (final_acc && (state == ACC_CPU)) begin
            cpu_rdata <= mem_rdata;
        end else if (final_acc && (state == ACC_EXT)) begin
            ext_rdata <= mem_rdata;
        end
    end

    // Write strobe only on the last access cycle so a multi-cycle write hits memory once.
    always_comb begin
        mem_en     = in_acc;
        mem_addr   = in_acc ? addr_p1 : 32'd0;
        mem_wdata  = in_acc ? wdata_p1 : 32'd0;
        mem_byteen = final_acc ? byteen_p1 : 4'd0;
        cpu_stall  = cpu_req && (state != DONE_CPU);
        ext_done   = (state == DONE_EXT);
    end

endmodule
